// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 keyboard receiver: pin sync, clock glitch filter, frame deframer, scancode FIFO
module ps2_rx #(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       n_rst_async,
    input  logic       ps2_clk_async,
    input  logic       ps2_data_async,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    input  logic       scancode_ack,
    output logic       frame_error,
    output logic       overflow
);

    localparam int FCW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    localparam logic [FCW-1:0] FILT_LAST  = FCW'(FILTER_CYCLES - 1);
    localparam logic [TCW-1:0] TO_LAST    = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  FIFO_FULL  = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic           clk_s1;
    logic           clk_s2;
    logic           dat_s1;
    logic           dat_s2;
    logic           clk_filt;
    logic           clk_filt_d;
    logic [FCW-1:0] filt_cnt;
    logic           fall_edge;

    logic [1:0]     state;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift;
    logic           parity_bit;
    logic [TCW-1:0] to_cnt;
    logic           timeout_hit;
    logic           frame_ok;
    logic           push;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           full;
    logic           pop;
    logic           wr_en;

    // Two-flop synchronizers on both pins; idle-high so reset to 1
    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk_async;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data_async;
            dat_s2 <= dat_s1;
        end
    end

    // Glitch filter: the filtered clock follows the synced clock only after it
    // has disagreed for FILTER_CYCLES consecutive cycles
    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s2 == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_LAST) begin
            clk_filt <= clk_s2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FCW'(1);
        end
    end

    // Delayed copy of the filtered clock for falling-edge detection
    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            clk_filt_d <= 1'b1;
        end else begin
            clk_filt_d <= clk_filt;
        end
    end

    assign fall_edge   = clk_filt_d & ~clk_filt;
    assign timeout_hit = (state != S_IDLE) && !fall_edge && (to_cnt == TO_LAST);
    // Stop bit must be high and the nine data+parity bits must have odd parity
    assign frame_ok    = dat_s2 & (^shift ^ parity_bit);
    assign push        = fall_edge && (state == S_STOP) && frame_ok;

    // Frame deframer with inter-edge timeout; frame_error is a registered pulse
    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            state       <= S_IDLE;
            bit_cnt     <= 3'd0;
            shift       <= 8'h00;
            parity_bit  <= 1'b0;
            to_cnt      <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            if (timeout_hit) begin
                state       <= S_IDLE;
                to_cnt      <= '0;
                frame_error <= 1'b1;
            end else if (fall_edge) begin
                to_cnt <= '0;
                case (state)
                    S_IDLE: begin
                        if (!dat_s2) begin
                            state   <= S_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        shift   <= {dat_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        parity_bit <= dat_s2;
                        state      <= S_STOP;
                    end
                    default: begin
                        if (!frame_ok) begin
                            frame_error <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                endcase
            end else if (state != S_IDLE) begin
                to_cnt <= to_cnt + TCW'(1);
            end
        end
    end

    assign scancode_valid = (count != '0);
    assign scancode       = scancode_valid ? mem[rd_ptr] : 8'h00;
    assign full           = (count == FIFO_FULL);
    assign pop            = scancode_valid & scancode_ack;
    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign wr_en          = push & (~full | pop);

    // Show-ahead scancode FIFO with sticky overflow on dropped bytes
    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= shift;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - self-checking bench for ps2_rx
module tb_ps2_rx;

    localparam int FILT  = 8;
    localparam int TMO   = 400;
    localparam int DEPTH = 4;
    localparam int H     = 20;
    // raw pin edge -> 2 sync flops -> FILT filter cycles -> edge register
    localparam int LAT   = 3 + FILT;

    logic       clk;
    logic       n_rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scancode;
    logic       scancode_valid;
    logic       scancode_ack;
    logic       frame_error;
    logic       overflow;

    ps2_rx #(
        .FILTER_CYCLES (FILT),
        .TIMEOUT_CYCLES(TMO),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .n_rst_async   (n_rst),
        .ps2_clk_async (ps2_clk),
        .ps2_data_async(ps2_data),
        .scancode      (scancode),
        .scancode_valid(scancode_valid),
        .scancode_ack  (scancode_ack),
        .frame_error   (frame_error),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc++;

    int err_count;
    int last_err_cyc;
    int wide_err;
    bit prev_err;
    always @(negedge clk) begin
        if (frame_error === 1'b1) begin
            err_count++;
            last_err_cyc = cyc;
            if (prev_err) wide_err++;
        end
        prev_err = (frame_error === 1'b1);
    end

    int tests;
    int fails;
    int last_fall_cyc;
    byte unsigned q[$];
    bit m_ovf;

    typedef struct {
        logic [7:0] d;
        bit         badp;
        bit         stop;
        int         acks;
        logic       valid;
        logic [7:0] code;
        int         err;
        logic       ovf;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input bit badp, input bit stop);
        return {stop, (~^d) ^ badp, d, 1'b0};
    endfunction

    task automatic do_ack();
        @(negedge clk);
        scancode_ack = 1'b1;
        @(negedge clk);
        scancode_ack = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic check_model(input string tag);
        check({tag, "_valid"}, scancode_valid, q.size() != 0);
        check({tag, "_code"}, scancode, (q.size() != 0) ? q[0] : 8'h00);
        check({tag, "_ovf"}, overflow, m_ovf);
    endtask

    // Device-side frame generator: data set while clock high, receiver samples on fall
    task automatic send_bits(input logic [10:0] f, input int n, input bit ack_pulse, input bit chk_lat);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            for (int c = 0; c < H; c++) begin
                @(negedge clk);
                if (ack_pulse && i == 10) scancode_ack = (c == LAT - 2);
                if (chk_lat && i == 10 && c == LAT - 2)
                    check("lat_valid_before", scancode_valid, 1'b0);
                if (chk_lat && i == 10 && c == LAT - 1) begin
                    check("lat_valid_after", scancode_valid, 1'b1);
                    check("lat_code_after", scancode, f[8:1]);
                end
            end
            ps2_clk = 1'b1;
        end
        repeat (H) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic send_model(input logic [7:0] d);
        send_bits(mk(d, 1'b0, 1'b1), 11, 1'b0, 1'b0);
        if (q.size() < DEPTH) q.push_back(d);
        else m_ovf = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("rst_valid", scancode_valid, 1'b0);
        check("rst_code", scancode, 8'h00);
        check("rst_err", frame_error, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int e0;
        logic [7:0] rd[4];

        tbl[0] = '{8'h1C, 1'b0, 1'b1, 0, 1'b1, 8'h1C, 0, 1'b0};
        tbl[1] = '{8'h1C, 1'b1, 1'b1, 1, 1'b0, 8'h00, 1, 1'b0};
        tbl[2] = '{8'h1C, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1, 1'b0};
        tbl[3] = '{8'h1C, 1'b0, 1'b1, 0, 1'b1, 8'h1C, 0, 1'b0};
        tbl[4] = '{8'h32, 1'b0, 1'b1, 0, 1'b1, 8'h1C, 0, 1'b0};
        tbl[5] = '{8'h21, 1'b0, 1'b1, 0, 1'b1, 8'h1C, 0, 1'b0};
        tbl[6] = '{8'h23, 1'b0, 1'b1, 0, 1'b1, 8'h1C, 0, 1'b0};
        tbl[7] = '{8'h24, 1'b0, 1'b1, 0, 1'b1, 8'h1C, 0, 1'b1};

        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        scancode_ack = 1'b0;
        n_rst = 1'b1;
        #1 n_rst = 1'b0;
        repeat (3) @(negedge clk);
        check("init_valid", scancode_valid, 1'b0);
        check("init_code", scancode, 8'h00);
        check("init_err", frame_error, 1'b0);
        check("init_ovf", overflow, 1'b0);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);

        // Directed table: good/bad parity/bad stop, then fill past full
        for (int i = 0; i < 8; i++) begin
            repeat (tbl[i].acks) do_ack();
            e0 = err_count;
            send_bits(mk(tbl[i].d, tbl[i].badp, tbl[i].stop), 11, 1'b0, i == 0);
            repeat (5) @(negedge clk);
            check($sformatf("tbl%0d_valid", i), scancode_valid, tbl[i].valid);
            check($sformatf("tbl%0d_code", i), scancode, tbl[i].code);
            check($sformatf("tbl%0d_err", i), err_count - e0, tbl[i].err);
            check($sformatf("tbl%0d_ovf", i), overflow, tbl[i].ovf);
        end
        rd = '{8'h1C, 8'h32, 8'h21, 8'h23};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_code", i), scancode, rd[i]);
            do_ack();
        end
        check("drain_empty", scancode_valid, 1'b0);
        check("drain_code0", scancode, 8'h00);
        check("drain_ovf_sticky", overflow, 1'b1);
        do_ack();
        check("ack_empty_ignored", scancode_valid, 1'b0);

        // Full FIFO with ack coinciding with the push
        do_reset();
        send_model(8'h1C);
        send_model(8'h32);
        send_model(8'h21);
        send_model(8'h23);
        check_model("full4");
        send_bits(mk(8'hF0, 1'b0, 1'b1), 11, 1'b1, 1'b0);
        void'(q.pop_front());
        q.push_back(8'hF0);
        repeat (5) @(negedge clk);
        check_model("fullpp");
        rd = '{8'h32, 8'h21, 8'h23, 8'hF0};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fullpp%0d_code", i), scancode, rd[i]);
            do_ack();
        end
        check("fullpp_empty", scancode_valid, 1'b0);

        // Glitch while idle, then truncated frame and timeout
        @(negedge clk);
        ps2_data = 1'b0;
        repeat (5) @(negedge clk);
        e0 = err_count;
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (TMO + 50) @(negedge clk);
        check("glitch_no_err", err_count - e0, 0);
        send_bits(mk(8'h05, 1'b0, 1'b1), 4, 1'b0, 1'b0);
        for (int k = 0; k < TMO + 100 && err_count == e0; k++) @(negedge clk);
        check("timeout_err", err_count - e0, 1);
        check("timeout_lat", last_err_cyc - last_fall_cyc, LAT + TMO);
        send_model(8'hF0);
        check_model("post_to");
        check("post_to_err", err_count - e0, 1);
        do_ack();

        // Reset mid-frame with two bytes queued
        send_model(8'h1C);
        send_model(8'h32);
        check_model("pre_rst");
        send_bits(mk(8'h5A, 1'b0, 1'b1), 6, 1'b0, 1'b0);
        do_reset();
        send_model(8'h5A);
        check_model("after_rst");
        do_ack();
        check_model("after_rst_pop");

        // Randomized frames and acks against the queue model
        do_reset();
        for (int n = 0; n < 14; n++) begin
            logic [7:0] d;
            bit bp, st, good;
            repeat ($urandom_range(0, 2)) do_ack();
            d = 8'($urandom);
            bp = ($urandom_range(0, 5) == 0);
            st = ($urandom_range(0, 5) != 0);
            good = !bp && st;
            e0 = err_count;
            send_bits(mk(d, bp, st), 11, 1'b0, 1'b0);
            repeat (5) @(negedge clk);
            if (good) begin
                if (q.size() < DEPTH) q.push_back(d);
                else m_ovf = 1'b1;
            end
            check_model($sformatf("rnd%0d", n));
            check($sformatf("rnd%0d_err", n), err_count - e0, good ? 0 : 1);
        end

        check("err_single_cycle", wide_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
PS/2 keyboard receiver that turns the raw keyboard clock/data pins into a queue of validated scancode bytes for the CPU, alongside the button synchronizers. It synchronizes and glitch-filters the device clock, deframes 11-bit PS/2 frames, checks parity, stop bit and timeout, and buffers bytes in a small show-ahead FIFO. It is receive-only; host-to-device transmission is out of scope.

Parameters:
FILTER_CYCLES, 8, consecutive identical synced samples required before the filtered PS/2 clock changes level
TIMEOUT_CYCLES, 100000, clk cycles allowed between filtered falling edges inside a frame (2 ms at 50 MHz)
FIFO_DEPTH, 4, scancode FIFO entries (power of two, >= 2)

Ports:
clk  in  1  system clock, 50 MHz
n_rst_async  in  1  asynchronous active-low reset
ps2_clk_async  in  1  raw PS/2 clock pin (idle high)
ps2_data_async  in  1  raw PS/2 data pin (idle high)
scancode  out  8  FIFO head byte; 8'h00 when FIFO empty
scancode_valid  out  1  FIFO not empty
scancode_ack  in  1  pop head when scancode_valid high
frame_error  out  1  one-cycle pulse on parity, stop-bit or timeout failure
overflow  out  1  sticky; set when a good byte is dropped because FIFO is full

Behaviour:
- Single clock domain (clk); one asynchronous active-low reset (n_rst_async) on every flop.
- Reset values: scancode 0, scancode_valid 0, frame_error 0, overflow 0, FIFO empty, FSM IDLE, sync flops and filtered clock 1.
- Sync: 2-flop synchronizer on each pin.
- Filter: counter tracks synced clock; filtered clock takes new level only after FILTER_CYCLES consecutive cycles at that level; shorter pulses ignored. Data is not filtered.
- Falling edge = filtered clock 1->0, registered; synced data sampled in that same cycle.
- FSM (acts only on falling edges except timeout):
  - IDLE: data 0 -> DATA, bit count 0, timeout counter cleared; data 1 -> stay IDLE, no error.
  - DATA: shift data in LSB first; after 8th bit -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: ok when data 1 and XOR(8 data bits, parity bit) = 1 (odd parity); ok -> push byte; not ok -> frame_error pulse, no push. Always -> IDLE.
- Timeout: in DATA/PARITY/STOP, counter increments each cycle, clears on every falling edge; when it reaches TIMEOUT_CYCLES -> IDLE and frame_error pulse. Counter frozen at 0 in IDLE.
- Latency: push occurs in cycle of the stop-bit falling edge; scancode_valid/scancode update the next cycle.
- FIFO: show-ahead; pop when scancode_valid & scancode_ack; ack while empty ignored.
- Full, push without pop: byte dropped, overflow set; overflow clears only on reset.
- Full, push and pop same cycle: both occur, occupancy unchanged, no overflow.
- Empty, push: ack in same cycle has no effect (valid was low).
- Pointer wrap: log2(FIFO_DEPTH)-bit pointers wrap naturally; occupancy counter 0..FIFO_DEPTH.
- Reset mid-frame: partial frame discarded, FIFO flushed, FSM IDLE.

Test Plan:
- Frame 0x1C, parity 0, stop 1 at 10 kHz PS/2 clock -> scancode_valid 1, scancode 0x1C one cycle after stop edge; pulse ack -> valid 0, scancode 0x00, frame_error never high.
- Frame 0x1C with parity 1 -> frame_error single-cycle pulse, scancode_valid stays 0; frame 0x1C with stop 0 -> same.
- Frames 0x1C,0x32,0x21,0x23,0x24 with no ack -> 4 entries, overflow 1; four acks read 0x1C,0x32,0x21,0x23; 0x24 absent; overflow remains 1.
- FIFO full with ack held high while 0xF0 arrives -> 0xF0 stored, overflow stays 0, occupancy stays 4.
- 3-cycle low glitch on ps2_clk_async while idle with data low -> FSM stays IDLE, no error; then start bit plus 3 data bits and clock stops -> frame_error exactly TIMEOUT_CYCLES after last edge; following 0xF0 frame received correctly.
- Assert n_rst_async after bit 5 of a frame with 2 bytes queued -> all outputs 0 immediately; next full frame 0x5A received as only entry.
